// File: rtl/lsp_get_tdist.sv
// Total weighted LSP distortion L_tdist for one MA-predictor mode (G.729 Qua_Lsp datapath).
// Optional sticky saturation flag port `ovf` when LSP_GET_TDIST_OVF_FLAG_EN is defined.
module lsp_get_tdist #(
  parameter int M   = 10,
  parameter int SFT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] bufAddr,
  input  logic [10:0] rbufAddr,
  input  logic [10:0] wegtAddr,
  input  logic [11:0] fgSumAddr,
  input  logic [10:0] tdistAddr,
  input  logic [31:0] memIn,
  input  logic [31:0] constMemIn,
  output logic [10:0] memReadAddr,
  output logic [11:0] constMemAddr,
  output logic [10:0] memWriteAddr,
  output logic [31:0] memOut,
  output logic        memWriteEn,
  output logic [31:0] tdist,
  output logic        done
`ifdef LSP_GET_TDIST_OVF_FLAG_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [2:0] {IDLE, RD_BUF, RD_RBUF, RD_WEGT, CALC, WRITE, DONE} state_t;

  localparam int JW = $clog2(M + 1);
  localparam int SW = 32 + SFT;

  state_t             state;
  logic [JW-1:0]      j, jNext;
  logic signed [15:0] bufReg, rbufReg, fgReg, wegtVal;
  logic signed [31:0] acc, accNext;

  logic signed [16:0]   diffWide;
  logic signed [15:0]   diff, tmp, sft;
  logic signed [31:0]   prod, lAcc, shSat, macTerm;
  logic signed [SW-1:0] shWide;
  logic signed [32:0]   sumWide;
  logic                 subSat, multSat, lMultSat, shlSat, macMultSat, addSat;

  // Element term for index j; wegt[j] is consumed straight off the read bus in CALC.
  always_comb begin
    wegtVal  = memIn[15:0];
    jNext    = j + JW'(1);

    diffWide = 17'(bufReg) - 17'(rbufReg);
    subSat   = diffWide[16] != diffWide[15];
    diff     = subSat ? (diffWide[16] ? 16'sh8000 : 16'sh7FFF) : diffWide[15:0];

    prod     = 32'(diff) * 32'(fgReg);
    multSat  = (diff == 16'sh8000) && (fgReg == 16'sh8000);
    tmp      = multSat ? 16'sh7FFF : prod[30:15];

    lMultSat = (wegtVal == 16'sh8000) && (tmp == 16'sh8000);
    lAcc     = lMultSat ? 32'sh7FFFFFFF : (32'(wegtVal) * 32'(tmp)) <<< 1;

    shWide   = SW'(lAcc) <<< SFT;
    shlSat   = (shWide[SW-1:31] != '0) && (shWide[SW-1:31] != '1);
    shSat    = shlSat ? (shWide[SW-1] ? 32'sh80000000 : 32'sh7FFFFFFF) : shWide[31:0];
    sft      = shSat[31:16];

    macMultSat = (sft == 16'sh8000) && (tmp == 16'sh8000);
    macTerm    = macMultSat ? 32'sh7FFFFFFF : (32'(sft) * 32'(tmp)) <<< 1;
    sumWide    = 33'(acc) + 33'(macTerm);
    addSat     = sumWide[32] != sumWide[31];
    accNext    = addSat ? (sumWide[32] ? 32'sh80000000 : 32'sh7FFFFFFF) : sumWide[31:0];
  end

  // NOTE: every register here uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      j            <= '0;
      acc          <= '0;
      bufReg       <= '0;
      rbufReg      <= '0;
      fgReg        <= '0;
      memReadAddr  <= '0;
      constMemAddr <= '0;
      memWriteAddr <= '0;
      memOut       <= '0;
      memWriteEn   <= 1'b0;
      tdist        <= '0;
      done         <= 1'b0;
`ifdef LSP_GET_TDIST_OVF_FLAG_EN
      ovf          <= 1'b0;
`endif
    end else if ((state == IDLE || state == DONE) && start) begin
      j            <= '0;
      acc          <= '0;
      done         <= 1'b0;
      memReadAddr  <= bufAddr;
      constMemAddr <= fgSumAddr;
      state        <= RD_BUF;
`ifdef LSP_GET_TDIST_OVF_FLAG_EN
      ovf          <= 1'b0;
`endif
    end else begin
      case (state)
        RD_BUF: begin
          memReadAddr <= rbufAddr + 11'(j);
          state       <= RD_RBUF;
        end
        RD_RBUF: begin
          bufReg      <= memIn[15:0];
          fgReg       <= constMemIn[15:0];
          memReadAddr <= wegtAddr + 11'(j);
          state       <= RD_WEGT;
        end
        RD_WEGT: begin
          rbufReg <= memIn[15:0];
          state   <= CALC;
        end
        CALC: begin
          acc <= accNext;
          j   <= jNext;
`ifdef LSP_GET_TDIST_OVF_FLAG_EN
          ovf <= ovf | subSat | multSat | lMultSat | shlSat | macMultSat | addSat;
`endif
          if (jNext == JW'(M)) begin
            memWriteEn   <= 1'b1;
            memWriteAddr <= tdistAddr;
            memOut       <= accNext;
            tdist        <= accNext;
            state        <= WRITE;
          end else begin
            memReadAddr  <= bufAddr + 11'(jNext);
            constMemAddr <= fgSumAddr + 12'(jNext);
            state        <= RD_BUF;
          end
        end
        WRITE: begin
          memWriteEn <= 1'b0;
          done       <= 1'b1;
          state      <= DONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsp_get_tdist.sv
// Directed scoreboard bench for lsp_get_tdist with 1-cycle-latency scratch/constant memory models.
module tb_lsp_get_tdist;
  localparam int M = 10;
  localparam logic [10:0] BUF_A   = 11'h100;
  localparam logic [10:0] RBUF_A  = 11'h200;
  localparam logic [10:0] WEGT_A  = 11'h300;
  localparam logic [10:0] TDIST_A = 11'h7F0;
  localparam logic [11:0] FG_A    = 12'h40A;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] memIn, constMemIn;
  logic [10:0] memReadAddr, memWriteAddr;
  logic [11:0] constMemAddr;
  logic [31:0] memOut, tdist;
  logic        memWriteEn, done;
`ifdef LSP_GET_TDIST_OVF_FLAG_EN
  logic        ovf;
`endif

  lsp_get_tdist dut (
    .clk(clk), .reset(reset), .start(start),
    .bufAddr(BUF_A), .rbufAddr(RBUF_A), .wegtAddr(WEGT_A),
    .fgSumAddr(FG_A), .tdistAddr(TDIST_A),
    .memIn(memIn), .constMemIn(constMemIn),
    .memReadAddr(memReadAddr), .constMemAddr(constMemAddr),
    .memWriteAddr(memWriteAddr), .memOut(memOut), .memWriteEn(memWriteEn),
    .tdist(tdist), .done(done)
`ifdef LSP_GET_TDIST_OVF_FLAG_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] scratch [2048];
  logic [31:0] constMem [4096];

  always @(posedge clk) begin
    memIn      <= scratch[memReadAddr];
    constMemIn <= constMem[constMemAddr];
  end

  int writeCount = 0;
  always @(posedge clk) if (memWriteEn === 1'b1) writeCount <= writeCount + 1;

  int          nChecks = 0;
  int          nPassed = 0;
  logic [31:0] expQ [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPassed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic fill(input logic [15:0] b, input logic [15:0] r, input logic [15:0] w,
                      input logic [15:0] f, input bit same);
    logic [15:0] bv;
    for (int i = 0; i < M; i++) begin
      bv = same ? b + 16'(i * 2359) : b;
      scratch[int'(BUF_A) + i]  = {16'hDEAD, bv};
      scratch[int'(RBUF_A) + i] = {16'hBEEF, (same ? bv : r)};
      scratch[int'(WEGT_A) + i] = {16'hA5A5, w};
      constMem[int'(FG_A) + i]  = {16'h5A5A, f};
    end
  endtask

  // Launch a run, pop the scoreboard on the write pulse, and time the done edge.
  task automatic runCase(input string tag, input logic [31:0] exp, input int midStartK);
    int          doneK;
    int          wc0;
    logic [31:0] want;
    doneK = -1;
    wc0   = writeCount;
    expQ.push_back(exp);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, " done drop"}, {31'b0, done}, 32'd0);
    for (int k = 2; k <= 100 && doneK < 0; k++) begin
      @(negedge clk);
      start = (k == midStartK);
      if (memWriteEn === 1'b1 && expQ.size() != 0) begin
        want = expQ.pop_front();
        check({tag, " memOut"}, memOut, want);
        check({tag, " wr addr"}, {21'b0, memWriteAddr}, {21'b0, TDIST_A});
      end
      if (done === 1'b1) doneK = k;
    end
    start = 1'b0;
    check({tag, " done edge"}, 32'(doneK), 32'd42);
    check({tag, " tdist"}, tdist, exp);
    check({tag, " write count"}, 32'(writeCount - wc0), 32'd1);
    check({tag, " queue drained"}, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    int wc0;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tdist", tdist, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset wen", {31'b0, memWriteEn}, 32'd0);
    check("reset memOut", memOut, 32'd0);
    check("reset rdaddr", {21'b0, memReadAddr}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    fill(16'h1234, 16'h0000, 16'h0800, 16'h7FFF, 1'b1);
    runCase("zero diff", 32'h00000000, 0);

    fill(16'h1000, 16'h0000, 16'h0800, 16'h7FFF, 1'b0);
    runCase("pos diff", 32'h13FD8014, 0);
`ifdef LSP_GET_TDIST_OVF_FLAG_EN
    check("pos diff ovf", {31'b0, ovf}, 32'd0);
`endif

    fill(16'h0000, 16'h1000, 16'h0800, 16'h7FFF, 1'b0);
    runCase("neg diff", 32'h14000000, 0);

    fill(16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b0);
    runCase("saturate", 32'h7FFFFFFF, 0);
`ifdef LSP_GET_TDIST_OVF_FLAG_EN
    check("saturate ovf", {31'b0, ovf}, 32'd1);
`endif

    // Abort with reset sampled at edge 20 of a run.
    fill(16'h1000, 16'h0000, 16'h0800, 16'h7FFF, 1'b0);
    wc0 = writeCount;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (18) @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("abort done", {31'b0, done}, 32'd0);
    check("abort tdist", tdist, 32'd0);
    check("abort wen", {31'b0, memWriteEn}, 32'd0);
`ifdef LSP_GET_TDIST_OVF_FLAG_EN
    check("abort ovf", {31'b0, ovf}, 32'd0);
`endif
    repeat (60) @(negedge clk);
    check("abort no write", 32'(writeCount - wc0), 32'd0);
    runCase("after abort", 32'h13FD8014, 0);

    fill(16'h0000, 16'h1000, 16'h0800, 16'h7FFF, 1'b0);
    runCase("mid start", 32'h14000000, 10);

    fill(16'h1000, 16'h0000, 16'h0800, 16'h7FFF, 1'b0);
    runCase("b2b first", 32'h13FD8014, 0);
    fill(16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b0);
    runCase("b2b second", 32'h7FFFFFFF, 0);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule

// File: doc/lsp_get_tdist.md
Name: lsp_get_tdist

Overview:
- Downstream neighbour of the LSP select stages in the Qua_Lsp datapath.
- After the first- and second-stage indices are chosen and the quantized vector buf[] is expanded, this block computes the total weighted distortion L_tdist for one MA-predictor mode.
- Inputs: buf[], rbuf[] and wegt[] from scratch memory, and fg_sum[] from constant memory.
- Output: the 32-bit result, written back to scratch memory and held on a port for the mode-select logic.

Parameters:
- M, 10, vector length (LSP order).
- SFT, 4, left shift applied before extract_h.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  begin computation; sampled only in IDLE.
- bufAddr  in  11  scratch base of buf[0..M-1].
- rbufAddr  in  11  scratch base of rbuf[0..M-1].
- wegtAddr  in  11  scratch base of wegt[0..M-1].
- fgSumAddr  in  12  constant-memory base of fg_sum[mode][0..M-1].
- tdistAddr  in  11  scratch destination of L_tdist.
- memIn  in  32  scratch read data; word value in [15:0].
- constMemIn  in  32  constant read data; word value in [15:0].
- memReadAddr  out  11  scratch read address.
- constMemAddr  out  12  constant read address.
- memWriteAddr  out  11  scratch write address.
- memOut  out  32  scratch write data.
- memWriteEn  out  1  scratch write strobe.
- tdist  out  32  final L_tdist, held until next start.
- done  out  1  completion flag.

Behaviour:
- Reset: all outputs are 0 and the FSM goes to IDLE. Reset mid-operation aborts the computation and issues no write.
- Memory timing: both memories have 1-cycle read latency. Data for the address driven in cycle n is valid in cycle n+1.
- FSM states: IDLE, RD_BUF, RD_RBUF, RD_WEGT, CALC, WRITE, DONE.
- IDLE:
  - On start=1: clear accumulator and j, drop done, go to RD_BUF.
  - start is ignored in every other state except DONE.
- RD_BUF: drive memReadAddr=bufAddr+j and constMemAddr=fgSumAddr+j.
- RD_RBUF: latch buf[j] and fg[j]; drive rbufAddr+j.
- RD_WEGT: latch rbuf[j]; drive wegtAddr+j.
- CALC: latch wegt[j], then compute the element term:
  - tmp = sub(buf,rbuf): 16-bit saturating.
  - tmp = mult(tmp,fg) = (tmp*fg)>>>15, arithmetic shift (floor); -32768*-32768 saturates to 32767.
  - L_acc = L_mult(wegt,tmp) = 2*wegt*tmp; 0x8000*0x8000 saturates to 0x7FFFFFFF.
  - sft = extract_h(L_shl(L_acc,SFT)), with the shift saturating to 0x7FFFFFFF / 0x80000000 on overflow.
  - acc = L_mac(acc,sft,tmp) = acc + L_mult(sft,tmp), 32-bit saturating.
  - Then j++. If j==M go to WRITE, else go to RD_BUF.
- WRITE: for one cycle, memWriteEn=1, memWriteAddr=tdistAddr, memOut=acc; also tdist<=acc.
- DONE: done=1, held high until start (which begins a new run and drops done) or reset.
- Latency: done first reads 1 at the clock edge 4*M+2 = 42 edges after the edge that sampled start.
- Saturation is sticky: once acc saturates, subsequent terms re-saturate per L_mac rules. There is no wrap-around anywhere.
- Addresses are base+j, with no wrap checking; the caller guarantees bases fit.

Optional Feature:
- Macro: LSP_GET_TDIST_OVF_FLAG_EN.
- When defined: adds output port ovf (1 bit).
  - Cleared on start and on reset.
  - Set sticky if any sub, mult, L_mult, L_shl or L_mac saturates during the run.
  - Valid while done=1.
- When undefined: no port, and no saturation-detect logic beyond what the arithmetic itself requires. Results are identical in both builds.

Test Plan:
- buf=rbuf=arbitrary, wegt=0x0800, fg=0x7FFF, start -> tdist=0x00000000 written at tdistAddr; done at edge 42.
- All j: buf=0x1000, rbuf=0, wegt=0x0800, fg=0x7FFF -> tdist=0x13FD8014.
- All j: buf=0, rbuf=0x1000, wegt=0x0800, fg=0x7FFF (negative diff, floor rounding) -> tdist=0x14000000.
- All j: buf=0x7FFF, rbuf=0x8000, wegt=0x7FFF, fg=0x7FFF -> sub/shl/mac saturate; tdist=0x7FFFFFFF; ovf=1 when LSP_GET_TDIST_OVF_FLAG_EN is defined.
- Assert reset at edge 20 of a run -> no memWriteEn pulse, done=0, tdist=0; a following start with the case-2 data -> 0x13FD8014.
- Pulse start again at edge 10 of a run -> ignored; single write, correct result. Then back-to-back runs with start issued while done=1 -> done drops and the second result is correct.
